// File: rtl/request_batch_scheduler.sv
// Request batch scheduler: gathers up to DEPTH addresses, sorts them with an
// odd-even transposition network (one pass per cycle), then streams them out
// in ascending order over a valid/ready handshake.
module request_batch_scheduler #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_addr,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_addr,
  output logic                           out_last,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     batch_count
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {StFill, StSort, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] addr_d [DEPTH];
  logic [CntW-1:0]   count_q, count_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [IdxW-1:0]   pass_q, pass_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              in_ready_q, in_ready_d;

  logic              accept;
  logic [CntW-1:0]   count_inc;
  logic              idle_hit;
  logic              last_entry;
  logic [DEPTH-1:0]  sort_vld;
  logic [DATA_W-1:0] sort_addr [DEPTH];

  assign accept     = (state_q == StFill) && in_valid && in_ready_q;
  assign count_inc  = count_q + CntW'(accept);
  // Counter reaching TIMEOUT on this edge forces the partial batch to sort.
  assign idle_hit   = (TIMEOUT != 0) && !accept && (count_q != '0) &&
                      ((32'(idle_q) + 32'd1) == TIMEOUT);
  assign last_entry = (CntW'(idx_q) == (count_q - CntW'(1)));

  // One odd-even transposition pass; key {~vld, addr} pushes empty slots last.
  always_comb begin
    sort_vld  = vld_q;
    sort_addr = addr_q;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (1'(i) == pass_q[0]) begin
        if ({~vld_q[i], addr_q[i]} > {~vld_q[i+1], addr_q[i+1]}) begin
          sort_vld[i]    = vld_q[i+1];
          sort_vld[i+1]  = vld_q[i];
          sort_addr[i]   = addr_q[i+1];
          sort_addr[i+1] = addr_q[i];
        end
      end
    end
  end

  // Next-state logic for the FILL / SORT / DRAIN controller and slot storage.
  always_comb begin
    state_d    = state_q;
    vld_d      = vld_q;
    addr_d     = addr_q;
    count_d    = count_q;
    idle_d     = idle_q;
    pass_d     = pass_q;
    idx_d      = idx_q;
    in_ready_d = in_ready_q;

    unique case (state_q)
      StFill: begin
        in_ready_d = 1'b1;
        if (accept) begin
          vld_d[count_q[IdxW-1:0]]  = 1'b1;
          addr_d[count_q[IdxW-1:0]] = in_addr;
          count_d                   = count_inc;
        end
        if (accept || (count_q == '0)) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
        if ((accept && (count_inc == CntW'(DEPTH))) ||
            (flush && (count_inc != '0)) || idle_hit) begin
          state_d    = StSort;
          pass_d     = '0;
          in_ready_d = 1'b0;
        end
      end
      StSort: begin
        vld_d  = sort_vld;
        addr_d = sort_addr;
        pass_d = pass_q + IdxW'(1);
        if (pass_q == IdxW'(DEPTH - 1)) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (last_entry) begin
            state_d    = StFill;
            count_d    = '0;
            vld_d      = '0;
            idle_d     = '0;
            in_ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State and storage registers; reset discards any batch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      vld_q      <= '0;
      count_q    <= '0;
      idle_q     <= '0;
      pass_q     <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      vld_q      <= vld_d;
      count_q    <= count_d;
      idle_q     <= idle_d;
      pass_q     <= pass_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

  // Outputs decoded purely from registers.
  assign in_ready    = in_ready_q;
  assign busy        = (state_q != StFill);
  assign out_valid   = (state_q == StDrain);
  assign out_addr    = out_valid ? addr_q[idx_q] : '0;
  assign out_last    = out_valid && last_entry;
  assign batch_count = count_q;

endmodule

// File: tb/tb_request_batch_scheduler.sv
// Directed + randomized bench for request_batch_scheduler. Expected output
// order comes from a plain sorted copy of the accepted addresses.
module tb_request_batch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_last, busy;
  logic [11:0] in_addr, out_addr;
  logic [3:0]  batch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] model_q[$];
  logic [11:0] exp_q[$];

  request_batch_scheduler #(.DATA_W(12), .DEPTH(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .batch_count(batch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept_one(input logic [11:0] a, input logic fl);
    in_valid = 1'b1;
    in_addr  = a;
    flush    = fl;
    check("in_ready_fill", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    model_q.push_back(a);
    check("batch_count_fill", 32'(batch_count), 32'(model_q.size()));
  endtask

  task automatic build_expected();
    logic [11:0] t;
    exp_q = model_q;
    for (int i = 0; i < exp_q.size(); i++) begin
      for (int j = 0; j < exp_q.size() - 1 - i; j++) begin
        if (exp_q[j] > exp_q[j+1]) begin
          t          = exp_q[j];
          exp_q[j]   = exp_q[j+1];
          exp_q[j+1] = t;
        end
      end
    end
  endtask

  // Called at the negedge just after the edge that entered SORT.
  task automatic wait_sort(input int exp_lat);
    int k = 0;
    while (!out_valid && k < 40) begin
      check("in_ready_sort", 32'(in_ready), 32'd0);
      step();
      k++;
    end
    check("sort_latency", 32'(k), 32'(exp_lat));
  endtask

  // mode 0: ready always, 1: toggling 1,0,1,0..., 2: random.
  task automatic drain(input int mode, input int max_out, input logic hold_in);
    int   i = 0;
    int   guard = 0;
    int   want;
    logic r;
    logic tog = 1'b1;
    build_expected();
    want = (max_out < exp_q.size()) ? max_out : exp_q.size();
    while (i < want && guard < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tog; tog = ~tog; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (hold_in) begin
        in_valid = 1'b1;
        in_addr  = 12'($urandom);
      end
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_addr", 32'(out_addr), 32'(exp_q[i]));
      check("out_last", 32'(out_last), 32'(i == exp_q.size() - 1));
      check("busy_drain", 32'(busy), 32'd1);
      check("in_ready_drain", 32'(in_ready), 32'd0);
      check("count_drain", 32'(batch_count), 32'(exp_q.size()));
      step();
      guard++;
      if (r) i++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_count", 32'(i), 32'(want));
  endtask

  task automatic check_idle();
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_count", 32'(batch_count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    model_q.delete();
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] t1 [8];
    int          n;
    int          k;
    t1 = '{12'h300, 12'h010, 12'hFFF, 12'h010, 12'h7A2, 12'h000, 12'h123, 12'h456};
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_addr   = '0;

    // Reset values
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(batch_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_in_ready_pre", 32'(in_ready), 32'd0);
    step();
    check("rel_in_ready_post", 32'(in_ready), 32'd1);

    // 1: full batch, ready always
    for (int i = 0; i < 8; i++) accept_one(t1[i], 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    wait_sort(8);
    drain(0, 8, 1'b0);
    check_idle();

    // 2: flush of a partial batch
    accept_one(12'h050, 1'b0);
    accept_one(12'h020, 1'b0);
    accept_one(12'h040, 1'b0);
    flush_pulse();
    check("flush_busy", 32'(busy), 32'd1);
    wait_sort(8);
    drain(0, 8, 1'b0);
    check_idle();

    // 3: empty flush ignored, then timeout
    flush_pulse();
    check("empty_flush_busy", 32'(busy), 32'd0);
    check("empty_flush_in_ready", 32'(in_ready), 32'd1);
    check("empty_flush_count", 32'(batch_count), 32'd0);
    accept_one(12'h00A, 1'b0);
    accept_one(12'h005, 1'b0);
    k = 0;
    while (!busy && k < 40) begin
      step();
      k++;
    end
    check("timeout_cycles", 32'(k), 32'd16);
    wait_sort(8);
    drain(2, 8, 1'b0);
    check_idle();

    // 4: backpressure with in_valid held through SORT/DRAIN
    for (int i = 0; i < 8; i++) accept_one(12'($urandom), 1'b0);
    in_valid = 1'b1;
    in_addr  = 12'h5A5;
    wait_sort(8);
    drain(1, 8, 1'b1);
    check_idle();

    // 5: flush in the same cycle as the 8th accept
    for (int i = 0; i < 7; i++) accept_one(12'($urandom_range(0, 31)), 1'b0);
    accept_one(12'($urandom_range(0, 31)), 1'b1);
    check("flush_acc_busy", 32'(busy), 32'd1);
    wait_sort(8);
    drain(2, 8, 1'b0);
    check_idle();

    // 6: asynchronous reset mid-DRAIN
    for (int i = 0; i < 8; i++) accept_one(12'($urandom), 1'b0);
    wait_sort(8);
    drain(0, 3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(batch_count), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rel_in_ready_pre", 32'(in_ready), 32'd0);
    step();
    check("mid_rel_in_ready_post", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) accept_one(12'($urandom), 1'b0);
    flush_pulse();
    wait_sort(8);
    drain(2, 8, 1'b0);
    check_idle();

    // Random batches of random size, duplicates likely
    for (int b = 0; b < 4; b++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        accept_one(12'($urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom), 1'b0);
      end
      if (n < 8) flush_pulse();
      wait_sort(8);
      drain(2, 8, 1'b0);
      check_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
